// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider family and its receive-side
// ratio checker: FSM state encodings and the nominal divide ratios.
package clk_div_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Nominal periods of the divider outputs, in source clock cycles
    localparam int DIV4_PERIOD  = 4;
    localparam int DIV16_PERIOD = 16;

endpackage

// File: rtl/clock_ratio_checker_if.sv
// Monitor bus of the clock ratio checker: control and divided clock in,
// measurement results and status pulses out.
interface clock_ratio_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             div_in;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             err;
    logic             timeout;

    // Side that drives the divided clock and the enable
    modport master (
        output en, div_in,
        input  period, period_vld, locked, err, timeout
    );

    // Checker side
    modport slave (
        input  en, div_in,
        output period, period_vld, locked, err, timeout
    );
endinterface

// File: rtl/clock_ratio_checker_sync_edge_det.sv
// Brings the asynchronous divided clock into the clk domain through a
// flop chain and flags its rising edges with a one-cycle pulse.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nRst,
    input  logic d_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!nRst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/clock_ratio_checker.sv
// Receive-side checker for a counter-based clock divider. Measures the
// period of the divided clock in clk cycles, locks after LOCK_CNT
// consecutive in-tolerance periods and reports bad periods and a lost clock.
module clock_ratio_checker
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int EXP_PERIOD  = DIV16_PERIOD,
    parameter int TOL         = 0,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nRst,
    clock_ratio_checker_if.slave  bus
);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_PERIOD);
    localparam logic        [CNT_W:0] TOL_U = (CNT_W+1)'(TOL);
    localparam logic [MATCH_W-1:0]    LOCK_M = MATCH_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [MATCH_W-1:0]   match_q;
    logic [CNT_W-1:0]     period_q;
    logic                 vld_q;
    logic                 locked_q;
    logic                 err_q;
    logic                 timeout_q;

    logic                 rise;
    logic                 cnt_sat;
    logic                 good;
    logic signed [CNT_W:0] dev;
    logic [MATCH_W-1:0]   match_d;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Magnitude of a signed deviation
    function automatic logic [CNT_W:0] abs_dev(input logic signed [CNT_W:0] d);
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .nRst   (nRst),
        .d_i    (bus.div_in),
        .rise_o (rise)
    );

    // The counter value at a rise is the period just completed, so the
    // tolerance test is made on cnt_q directly.
    always_comb begin
        dev     = $signed({1'b0, cnt_q}) - EXP_S;
        good    = (abs_dev(dev) <= TOL_U);
        cnt_sat = &cnt_q;
        match_d = match_q + 1'b1;
    end

    // Measurement FSM with counter, lock qualifier and registered outputs
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            match_q   <= '0;
            period_q  <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            if (!bus.en) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                match_q  <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // No reference edge yet: the first rise only starts timing
                        cnt_q    <= '0;
                        locked_q <= 1'b0;
                        if (rise) begin
                            state_q <= ST_ACQ;
                            cnt_q   <= CNT_ONE;
                            match_q <= '0;
                        end
                    end
                    ST_ACQ, ST_LOCKED: begin
                        if (rise) begin
                            // A rise in the saturation cycle still counts as a period
                            cnt_q    <= CNT_ONE;
                            period_q <= cnt_q;
                            vld_q    <= 1'b1;
                            if (good) begin
                                if (state_q == ST_ACQ) begin
                                    match_q <= match_d;
                                    if (match_d == LOCK_M) begin
                                        state_q  <= ST_LOCKED;
                                        locked_q <= 1'b1;
                                    end
                                end
                            end else begin
                                err_q    <= 1'b1;
                                match_q  <= '0;
                                state_q  <= ST_ACQ;
                                locked_q <= 1'b0;
                            end
                        end else if (cnt_sat) begin
                            // Clock lost: report once and wait for a fresh reference edge
                            timeout_q <= 1'b1;
                            state_q   <= ST_IDLE;
                            cnt_q     <= '0;
                            match_q   <= '0;
                            locked_q  <= 1'b0;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        cnt_q    <= '0;
                        match_q  <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.period     = period_q;
    assign bus.period_vld = vld_q;
    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.timeout    = timeout_q;
endmodule
